// File: rtl/ref_force_acc_bank.sv
// Per-channel reference-particle force accumulators: sums partial forces by reference ID,
// evicts a finished sum on ID change, drains all channels on flush through a small output FIFO.
module ref_force_acc_bank #(
    parameter int  NUM_CH     = 7,
    parameter int  DATA_WIDTH = 32,
    parameter int  ACC_WIDTH  = 40,
    parameter int  ID_WIDTH   = 16,
    parameter int  FIFO_DEPTH = 4,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CH_W-1:0]         in_ch,
    input  logic [ID_WIDTH-1:0]     in_ref_id,
    input  logic [3*DATA_WIDTH-1:0] in_force,
    input  logic                    flush,
    output logic                    flush_done,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CH_W-1:0]         out_ch,
    output logic [ID_WIDTH-1:0]     out_ref_id,
    output logic [3*DATA_WIDTH-1:0] out_force
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_DONE} state_t;

    function automatic logic signed [ACC_WIDTH-1:0] sext(input logic signed [DATA_WIDTH-1:0] d);
        return ACC_WIDTH'(d);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [ACC_WIDTH-1:0] a);
        if (a > SAT_MAX) return SAT_MAX[DATA_WIDTH-1:0];
        if (a < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
        return a[DATA_WIDTH-1:0];
    endfunction

    state_t                      r_state, w_state_nxt;
    logic [CH_W-1:0]             r_ptr, w_ptr_nxt;
    logic                        r_occ [NUM_CH];
    logic [ID_WIDTH-1:0]         r_id  [NUM_CH];
    logic signed [ACC_WIDTH-1:0] r_acc [NUM_CH][3];

    logic [CH_W-1:0]             r_f_ch    [FIFO_DEPTH];
    logic [ID_WIDTH-1:0]         r_f_id    [FIFO_DEPTH];
    logic [3*DATA_WIDTH-1:0]     r_f_force [FIFO_DEPTH];
    logic [PTR_W-1:0]            r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]            r_count;

    logic                        w_full, w_load, w_hit, w_evict;
    logic                        w_scan_occ, w_scan_push, w_scan_adv, w_push, w_pop;
    logic [CH_W-1:0]             w_src_ch;
    logic [3*DATA_WIDTH-1:0]     w_push_force;

    // A free FIFO slot is demanded even for samples that will not evict.
    assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
    assign in_ready    = rst && (r_state == S_IDLE) && !w_full;
    assign w_load      = in_valid && in_ready && (int'(in_ch) < NUM_CH);
    assign w_hit       = r_occ[in_ch] && (r_id[in_ch] == in_ref_id);
    assign w_evict     = w_load && r_occ[in_ch] && !w_hit;
    assign w_scan_occ  = r_occ[r_ptr];
    assign w_scan_push = (r_state == S_FLUSH) && w_scan_occ && !w_full;
    assign w_scan_adv  = (r_state == S_FLUSH) && (!w_scan_occ || !w_full);
    assign w_push      = w_evict || w_scan_push;
    assign w_pop       = out_valid && out_ready;
    assign w_src_ch    = (r_state == S_FLUSH) ? r_ptr : in_ch;

    always_comb begin
        w_push_force = '0;
        for (int k = 0; k < 3; k++)
            w_push_force[k*DATA_WIDTH +: DATA_WIDTH] = sat(r_acc[w_src_ch][k]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (flush) begin
                    w_state_nxt = S_FLUSH;
                    w_ptr_nxt   = '0;
                end
            end
            S_FLUSH: begin
                if (w_scan_adv) begin
                    if (r_ptr == CH_W'(NUM_CH - 1)) w_state_nxt = S_DONE;
                    else                            w_ptr_nxt   = r_ptr + CH_W'(1);
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Loads happen only in IDLE and scan clears only in FLUSH, so they never collide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_occ[c] <= 1'b0;
                r_id[c]  <= '0;
                for (int k = 0; k < 3; k++) r_acc[c][k] <= '0;
            end
        end else begin
            if (w_load) begin
                r_occ[in_ch] <= 1'b1;
                r_id[in_ch]  <= in_ref_id;
                for (int k = 0; k < 3; k++)
                    r_acc[in_ch][k] <= w_hit
                        ? r_acc[in_ch][k] + sext(in_force[k*DATA_WIDTH +: DATA_WIDTH])
                        : sext(in_force[k*DATA_WIDTH +: DATA_WIDTH]);
            end
            if (w_scan_push) r_occ[r_ptr] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_f_ch[r_wr_ptr]    <= w_src_ch;
            r_f_id[r_wr_ptr]    <= r_id[w_src_ch];
            r_f_force[r_wr_ptr] <= w_push_force;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset, so the head is masked while the FIFO is empty.
    assign out_valid  = (r_count != '0);
    assign out_ch     = out_valid ? r_f_ch[r_rd_ptr]    : '0;
    assign out_ref_id = out_valid ? r_f_id[r_rd_ptr]    : '0;
    assign out_force  = out_valid ? r_f_force[r_rd_ptr] : '0;
    assign flush_done = (r_state == S_DONE);

endmodule

// File: tb/tb_ref_force_acc_bank.sv
// Randomised scoreboard bench for ref_force_acc_bank against an ID-keyed reference model.
module tb_ref_force_acc_bank;
    localparam int NUM_CH = 7;
    localparam int DW     = 32;
    localparam int AW     = 40;
    localparam int IW     = 16;
    localparam int FD     = 4;
    localparam int CH_W   = 3;

    logic            clk = 1'b0;
    logic            rst, in_valid, in_ready, flush, flush_done, out_valid, out_ready;
    logic [CH_W-1:0] in_ch, out_ch;
    logic [IW-1:0]   in_ref_id, out_ref_id;
    logic [3*DW-1:0] in_force, out_force;

    always #5 clk = ~clk;

    ref_force_acc_bank #(
        .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .ID_WIDTH(IW), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
        .in_ref_id(in_ref_id), .in_force(in_force), .flush(flush), .flush_done(flush_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
        .out_ref_id(out_ref_id), .out_force(out_force)
    );

    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic [IW-1:0]   id;
        logic [3*DW-1:0] f;
    } ent_t;

    ent_t          sb[$];
    bit            m_occ [NUM_CH];
    logic [IW-1:0] m_id  [NUM_CH];
    longint        m_acc [NUM_CH][3];
    int            n_tests = 0, n_fail = 0, n_acc = 0, rdy_mode = 0;
    ent_t          mon_a, mon_e, mon_held;
    bit            mon_stalled = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm, input string why);
        n_tests++;
        n_fail++;
        $display("FAIL %s: %s", nm, why);
    endtask

    function automatic longint wrap_acc(input longint v);
        longint m = v & ((longint'(1) << AW) - 1);
        if (m >= (longint'(1) << (AW - 1))) m -= (longint'(1) << AW);
        return m;
    endfunction

    function automatic logic [DW-1:0] sat_dw(input longint v);
        longint hi = (longint'(1) << (DW - 1)) - 1;
        longint lo = -(longint'(1) << (DW - 1));
        if (v > hi) return DW'(hi);
        if (v < lo) return DW'(lo);
        return DW'(v);
    endfunction

    function automatic logic [3*DW-1:0] mkf(input int x, input int y, input int z);
        return {DW'(z), DW'(y), DW'(x)};
    endfunction

    function automatic logic [3*DW-1:0] rnd_force();
        logic [3*DW-1:0] f;
        for (int k = 0; k < 3; k++)
            f[k*DW +: DW] = ($urandom_range(0, 3) == 0) ? DW'($urandom)
                                                        : DW'(int'($urandom_range(0, 2000)) - 1000);
        return f;
    endfunction

    function automatic void m_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_occ[c] = 1'b0;
            m_id[c]  = '0;
            for (int k = 0; k < 3; k++) m_acc[c][k] = 0;
        end
        sb.delete();
    endfunction

    function automatic void m_emit(input int c);
        ent_t e;
        e.ch = CH_W'(c);
        e.id = m_id[c];
        for (int k = 0; k < 3; k++) e.f[k*DW +: DW] = sat_dw(m_acc[c][k]);
        sb.push_back(e);
        m_occ[c] = 1'b0;
    endfunction

    function automatic void m_accept(input int c, input logic [IW-1:0] id, input logic [3*DW-1:0] f);
        if (c >= NUM_CH) return;
        if (m_occ[c] && m_id[c] == id) begin
            for (int k = 0; k < 3; k++)
                m_acc[c][k] = wrap_acc(m_acc[c][k] + longint'($signed(f[k*DW +: DW])));
            return;
        end
        if (m_occ[c]) m_emit(c);
        m_occ[c] = 1'b1;
        m_id[c]  = id;
        for (int k = 0; k < 3; k++) m_acc[c][k] = longint'($signed(f[k*DW +: DW]));
    endfunction

    function automatic void m_flush();
        for (int c = 0; c < NUM_CH; c++) if (m_occ[c]) m_emit(c);
    endfunction

    task automatic send(input int c, input logic [IW-1:0] id, input logic [3*DW-1:0] f);
        int t = 0;
        in_valid = 1'b1; in_ch = CH_W'(c); in_ref_id = id; in_force = f;
        while (!in_ready && t < 500) begin @(posedge clk); #1; t++; end
        if (!in_ready) fail_now("send_timeout", "in_ready never rose within 500 cycles");
        else begin
            m_accept(c, id, f);
            n_acc++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic do_flush(input bit chk_lat, input bit with_smp, input int c,
                            input logic [IW-1:0] id, input logic [3*DW-1:0] f);
        int t = 0, leaks = 0;
        if (with_smp) begin
            in_valid = 1'b1; in_ch = CH_W'(c); in_ref_id = id; in_force = f;
            while (!in_ready && t < 500) begin @(posedge clk); #1; t++; end
            if (in_ready) m_accept(c, id, f);
            else begin
                fail_now("flush_sample_timeout", "in_ready never rose within 500 cycles");
                in_valid = 1'b0;
            end
        end
        flush = 1'b1;
        m_flush();
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        t = 0;
        while (!flush_done && t < 500) begin
            if (in_ready) leaks++;
            @(posedge clk); #1; t++;
        end
        if (!flush_done) fail_now("flush_done_timeout", "no flush_done within 500 cycles");
        else begin
            if (in_ready) leaks++;
            if (chk_lat) begin
                chk("flush_done_latency", t + 1, NUM_CH + 1);
                chk("in_ready_during_flush", leaks, 0);
            end
            @(posedge clk); #1;
            chk("flush_done_single_pulse", flush_done, 1'b0);
            if (chk_lat) chk("in_ready_after_done", in_ready, 1'b1);
        end
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // Monitor: pops the scoreboard whenever the DUT hands over an entry.
    initial forever begin
        @(negedge clk);
        if (rst && out_valid) begin
            mon_a = {out_ch, out_ref_id, out_force};
            if (mon_stalled) chk("out_hold_stable", mon_a, mon_held);
            if (out_ready) begin
                if (sb.size() == 0) fail_now("unexpected_output", $sformatf("got 0x%0h with empty scoreboard", mon_a));
                else begin
                    mon_e = sb.pop_front();
                    chk("out_entry", mon_a, mon_e);
                end
                mon_stalled = 1'b0;
            end else begin
                mon_stalled = 1'b1;
                mon_held    = mon_a;
            end
        end else mon_stalled = 1'b0;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            rc, t;
        logic [IW-1:0] rid;
        logic [3*DW-1:0] rf;
        rst = 1'b0; in_valid = 1'b0; in_ch = '0; in_ref_id = '0; in_force = '0; flush = 1'b0;
        m_reset();
        repeat (3) @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_flush_done", flush_done, 1'b0);
        chk("rst_out_fields", {out_ch, out_ref_id, out_force}, '0);
        rst = 1'b1; #1;
        chk("in_ready_after_reset", in_ready, 1'b1);

        // accumulation then eviction on ID change
        send(0, 5, mkf(3, 0, 0));
        send(0, 5, mkf(4, 0, 0));
        send(0, 5, mkf(-2, 0, 0));
        send(0, 6, mkf(1, 0, 0));

        // saturation, both directions, plus an out-of-range channel
        send(2, 9, mkf(32'h7fffffff, -5, 1));
        send(2, 9, mkf(32'h7fffffff, -6, 2));
        send(2, 10, mkf(5, 0, 0));
        send(3, 20, mkf(int'(32'h80000000), 32'h7fffffff, 0));
        send(3, 20, mkf(int'(32'h80000000), 1, 0));
        send(3, 21, mkf(0, 0, 0));
        send(7, 1, mkf(99, 99, 99));
        do_flush(1'b1, 1'b0, 0, '0, '0);

        // flush ordering
        send(1, 11, mkf(10, 20, 30));
        send(4, 12, mkf(-10, -20, -30));
        send(6, 13, mkf(7, 8, 9));
        do_flush(1'b1, 1'b0, 0, '0, '0);

        // backpressure with five evictions
        rdy_mode = 1;
        repeat (2) @(posedge clk); #1;
        send(5, 100, mkf(1, 2, 3));
        n_acc = 0;
        fork
            begin
                for (int i = 1; i <= 5; i++) send(5, IW'(100 + i), mkf(i * 7, -i, i));
            end
            begin
                repeat (20) @(posedge clk); #1;
                chk("bp_accepted_count", n_acc, 4);
                chk("bp_in_ready_low", in_ready, 1'b0);
                chk("bp_out_valid", out_valid, 1'b1);
                rdy_mode = 0;
            end
        join
        do_flush(1'b1, 1'b0, 0, '0, '0);

        // flush with a full FIFO
        rdy_mode = 1;
        repeat (2) @(posedge clk); #1;
        send(0, 40, mkf(1, 1, 1));
        send(1, 41, mkf(2, 2, 2));
        send(3, 1, mkf(3, 3, 3));
        for (int i = 2; i <= 5; i++) send(3, IW'(i), mkf(i, -i, 0));
        chk("full_in_ready_low", in_ready, 1'b0);
        fork
            do_flush(1'b0, 1'b0, 0, '0, '0);
            begin
                repeat (15) @(posedge clk); #1;
                rdy_mode = 0;
            end
        join

        // randomised traffic with random consumer stalls
        rdy_mode = 2;
        for (int i = 0; i < 400; i++) begin
            rc  = int'($urandom_range(0, 7));
            rid = IW'($urandom_range(0, 3));
            rf  = rnd_force();
            if ($urandom_range(0, 39) == 0) do_flush(1'b0, 1'($urandom_range(0, 1)), rc, rid, rf);
            else send(rc, rid, rf);
        end
        rdy_mode = 0;
        do_flush(1'b0, 1'b0, 0, '0, '0);
        t = 0;
        while (sb.size() != 0 && t < 200) begin @(posedge clk); #1; t++; end
        chk("random_drained", sb.size(), 0);

        // reset in the middle of a flush with a non-empty FIFO
        rdy_mode = 1;
        repeat (2) @(posedge clk); #1;
        send(0, 7, mkf(1, 0, 0));
        send(2, 8, mkf(2, 0, 0));
        send(4, 9, mkf(3, 0, 0));
        flush = 1'b1;
        m_flush();
        @(posedge clk); #1;
        flush = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("pre_reset_out_valid", out_valid, 1'b1);
        rst = 1'b0; #1;
        m_reset();
        chk("midflush_rst_out_valid", out_valid, 1'b0);
        chk("midflush_rst_in_ready", in_ready, 1'b0);
        chk("midflush_rst_flush_done", flush_done, 1'b0);
        rdy_mode = 0;
        repeat (2) @(posedge clk); #1;
        rst = 1'b1; #1;
        chk("post_reset_in_ready", in_ready, 1'b1);
        send(0, 77, mkf(4, 5, 6));
        repeat (3) @(posedge clk); #1;
        chk("post_reset_no_eviction", out_valid, 1'b0);
        do_flush(1'b1, 1'b0, 0, '0, '0);

        t = 0;
        while (sb.size() != 0 && t < 200) begin @(posedge clk); #1; t++; end
        repeat (3) @(posedge clk); #1;
        chk("final_scoreboard_empty", sb.size(), 0);
        chk("final_out_valid", out_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ref_force_acc_bank.md
# ref_force_acc_bank

Parametrised bank of per-channel reference-particle force accumulators for the range-limited force pipeline. It sits between the force evaluation pipeline output and the home-cell write-back path. It accumulates signed fixed-point partial forces per filter channel, keyed by reference particle ID, and evicts a finished sum when that channel's reference ID changes. It drains all channels on a phase-change flush and serialises results through a small output FIFO with a valid/ready handshake.

## Interface
- NUM_CH, 7: accumulator channels (one per filter).
- DATA_WIDTH, 32: signed two's-complement width of each force component, in and out.
- ACC_WIDTH, 40: internal accumulator width per component; must be ≥ DATA_WIDTH.
- ID_WIDTH, 16: reference particle ID width.
- FIFO_DEPTH, 4: output FIFO entries; power of two, ≥ 2.
- CH_W = max(1, $clog2(NUM_CH)): derived, not overridable.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  partial force sample present.
- in_ready  out  1  sample accepted when in_valid && in_ready.
- in_ch  in  CH_W  target channel; value ≥ NUM_CH is dropped, with no state change.
- in_ref_id  in  ID_WIDTH  reference particle ID of the sample.
- in_force  in  3*DATA_WIDTH  {z,y,x} signed partial force.
- flush  in  1  one-cycle pulse; drain all channels (phase change).
- flush_done  out  1  one-cycle pulse when drain is complete.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer pops head when out_valid && out_ready.
- out_ch  out  CH_W  source channel of the result.
- out_ref_id  out  ID_WIDTH  reference ID of the result.
- out_force  out  3*DATA_WIDTH  {z,y,x} saturated accumulated force.

## Operation
- Per-channel state: occupied bit, ID register, three ACC_WIDTH accumulators.
- Accepted sample on channel c, IDLE state only:
  - c unoccupied: load the ID and the sign-extended force, and set occupied.
  - c occupied, ID equal: accumulate acc += sext(in_force), modulo 2^ACC_WIDTH.
  - c occupied, ID different: push {c, old ID, sat(old acc)} to the FIFO, then load the new ID and force. Only one FIFO push occurs.
- sat(): clamp to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1] per component.
- in_ready = rst && state==IDLE && fifo_count<FIFO_DEPTH. The check is conservative: a free slot is required even when no eviction results. The signal is combinational from registered state only and does not depend on in_valid.
- FSM states:
  - IDLE: a flush pulse moves to FLUSH with scan pointer 0. A sample accepted in the same cycle as flush is applied first and is included in the drain.
  - FLUSH: one channel per cycle at the scan pointer.
    - Occupied and FIFO not full: push the entry, clear occupied, advance.
    - Occupied and FIFO full: hold the pointer.
    - Unoccupied: advance.
    - After channel NUM_CH−1 is handled, go to DONE.
  - DONE: flush_done=1 for one cycle, then IDLE.
- flush is ignored in FLUSH and DONE.
- FIFO:
  - A push is permitted only when count<FIFO_DEPTH; there is no push-through on a simultaneous pop.
  - Simultaneous push and pop with count>0 leaves count unchanged.
  - Output order is push order.

## Timing
- Reset values: in_ready 0 while rst low; flush_done 0; out_valid 0; out_ch/out_ref_id/out_force 0.
- Reset also clears all occupied bits, the accumulators, the FIFO and the FSM (IDLE).
- Reset mid-flush or with a non-empty FIFO discards all contents without emitting them.
- Eviction latency: a sample accepted at edge N produces out_valid=1 with the entry from edge N.
- out_* is held stable while out_valid && !out_ready.
- Flush of k occupied channels with the consumer always ready: flush_done asserts NUM_CH+1 cycles after the flush edge, provided the FIFO never fills.
- in_ready is 0 for the whole FLUSH/DONE window and returns to 1 the cycle after flush_done.

## Test plan
- Accumulation and eviction: ch0 id 5 receives forces x=+3, +4, −2, then a sample with id 6 and x=+1. Required: one output {ch0, id5, x=5}; ch0 then holds id6 with x=1.
- Saturation: DATA_WIDTH=32, ch2 id 9 receives 0x7FFF_FFFF twice on x, then id 10 arrives. Required: the output has x=0x7FFF_FFFF. Repeat with negative values: x=0x8000_0000.
- Flush ordering: channels 1, 4 and 6 are occupied, out_ready=1, and flush is pulsed. Required: outputs appear in order ch1, ch4, ch6, and flush_done pulses exactly once, NUM_CH+1 cycles after flush.
- Backpressure: FIFO_DEPTH=4, out_ready=0, 5 evicting samples offered. Required: the first 4 are accepted, in_ready goes 0, and no entry is lost. Raising out_ready releases all 5 in order.
- Flush with a full FIFO: FIFO full and 3 channels occupied when flush is pulsed. Required: the scan stalls until out_ready pops, the 3 entries follow the existing 4, and there are no duplicates.
- Reset mid-flush: rst is driven low during FLUSH. Required: out_valid=0, in_ready=0 and flush_done=0 immediately. After release: in_ready=1, and a new sample is loaded as unoccupied (no eviction output).
